pll_clk_supervisor: RTL

//  Sits directly after the PLL in the 120 MHz domain. Filters the PLL lock flag, sequences the

---
 rtl/pll_clk_supervisor_pkg.sv | 17 +
 rtl/pll_clk_supervisor_tick_nco.sv | 45 ++++
 rtl/pll_clk_supervisor.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pll_clk_supervisor_pkg.sv
// Shared types for the PLL clock supervisor: FSM state encoding and a
// counter-width helper for the lock filter and settle counters.
package pll_sup_pkg;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_SETTLE = 2'd1,
    S_RUN    = 2'd2,
    S_LOST   = 2'd3
  } sup_state_e;

  // Bits needed to count 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pll_clk_supervisor_tick_nco.sv
// One fractional-rate tick channel: phase accumulator with a registered carry,
// re-registered onto the tick output; everything clears when not running+enabled.
module tick_nco #(
  parameter int ACC_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             en_i,
  input  logic [ACC_W-1:0] inc_i,
  output logic             tick_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             tick_q, tick_d;
  logic [ACC_W:0]   sum;

  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, inc_i};
    acc_d   = '0;
    carry_d = 1'b0;
    tick_d  = 1'b0;
    if (run_i && en_i) begin
      acc_d   = sum[ACC_W-1:0];
      carry_d = sum[ACC_W];
      tick_d  = carry_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
      tick_q  <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/pll_clk_supervisor.sv
// Lock-qualified reset sequencer and N_CH tick generator behind the PLL.
// Optional macro PLL_LOSS_CNT_EN adds the saturating loss_cnt output.
module pll_clk_supervisor
  import pll_sup_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int ACC_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 16,
  parameter int SETTLE_CYC  = 1024,
  parameter int LOSS_W      = 8
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic [N_CH*ACC_W-1:0] inc,
  input  logic [N_CH-1:0]       ch_en,
  output logic                  sys_rst,
  output logic                  ready,
  output logic [N_CH-1:0]       tick
`ifdef PLL_LOSS_CNT_EN
  ,
  output logic [LOSS_W-1:0]     loss_cnt
`endif
);

  localparam int FILT_W   = cnt_w(FILT_CYC);
  localparam int SETTLE_W = cnt_w(SETTLE_CYC);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk_s;
  logic [FILT_W-1:0]      filt_cnt_q;
  logic                   lock_f_q;
  sup_state_e             state_q, state_d;
  logic [SETTLE_W-1:0]    settle_cnt_q, settle_cnt_d;
  logic                   sys_rst_q, sys_rst_d;
  logic                   ready_q, ready_d;
  logic                   run;

  always_ff @(posedge refclk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end
  assign lk_s = sync_q[SYNC_STAGES-1];

  // Slow to accept lock, fail-fast on the first low sample.
  always_ff @(posedge refclk) begin
    if (rst || !lk_s) begin
      filt_cnt_q <= '0;
      lock_f_q   <= 1'b0;
    end else if (!lock_f_q) begin
      if (filt_cnt_q == FILT_W'(FILT_CYC - 1)) lock_f_q <= 1'b1;
      else                                     filt_cnt_q <= filt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q      <= S_WAIT;
      settle_cnt_q <= '0;
      sys_rst_q    <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      sys_rst_q    <= sys_rst_d;
      ready_q      <= ready_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = '0;
    case (state_q)
      S_WAIT:   if (lock_f_q) state_d = S_SETTLE;
      S_SETTLE: begin
        settle_cnt_d = settle_cnt_q + 1'b1;
        if (!lock_f_q)                                      state_d = S_WAIT;
        else if (settle_cnt_q == SETTLE_W'(SETTLE_CYC - 1)) state_d = S_RUN;
      end
      S_RUN:    if (!lock_f_q) state_d = S_LOST;
      S_LOST:   state_d = S_WAIT;
      default:  state_d = S_WAIT;
    endcase
  end

  // Outputs follow the next state so they change on the transition edge itself.
  always_comb begin
    run       = (state_d == S_RUN);
    ready_d   = run;
    sys_rst_d = !run;
  end

  assign sys_rst = sys_rst_q;
  assign ready   = ready_q;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    tick_nco #(
      .ACC_W (ACC_W)
    ) u_nco (
      .clk_i  (refclk),
      .rst_i  (rst),
      .run_i  (run),
      .en_i   (ch_en[gi]),
      .inc_i  (inc[gi*ACC_W +: ACC_W]),
      .tick_o (tick[gi])
    );
  end

`ifdef PLL_LOSS_CNT_EN
  logic [LOSS_W-1:0] loss_q;

  always_ff @(posedge refclk) begin
    if (rst)                                                   loss_q <= '0;
    else if (state_q == S_LOST && loss_q != {LOSS_W{1'b1}})    loss_q <= loss_q + 1'b1;
  end
  assign loss_cnt = loss_q;
`endif

endmodule
